// File: rtl/serial_add_unit.sv
// Bit-serial LSB-first add/subtract around one full adder, carry fed back through a register.
// Optional SERIAL_ADD_SAT_EN clamps an overflowing result (add -> all ones, sub -> zero).

module fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, sub_q, ovf_q;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] s_next, sum_fin;
    logic             ovf_next;

    fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c_in (carry),
        .s    (fa_s),
        .c_out(fa_c)
    );

    // Sum bits enter at the MSB so the last RUN edge leaves the result aligned.
    always_comb begin
        s_next           = s_sh >> 1;
        s_next[WIDTH-1]  = fa_s;
        ovf_next         = sub_q ? ~fa_c : fa_c;
`ifdef SERIAL_ADD_SAT_EN
        sum_fin = ovf_next ? (sub_q ? '0 : '1) : s_next;
`else
        sum_fin = s_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            sum_q <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_sub ? ~in_b : in_b;
                        carry <= in_sub;
                        sub_q <= in_sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh  <= s_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q <= sum_fin;
                        ovf_q <= ovf_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sum_q <= '0;
                        ovf_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset masks the outputs immediately rather than waiting for the edge.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign out_sum   = rst ? '0 : sum_q;
    assign out_ovf   = ovf_q && !rst;
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit at WIDTH=8; expectations follow SERIAL_ADD_SAT_EN if defined.

module tb_serial_add_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_ovf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, check no early valid / no leakage, then the result at edge k+W.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_sum, input logic exp_ovf);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "_ready_before"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_a = '1; in_b = '1;
        for (int i = 1; i < W; i++) begin
            check({tag, "_early_valid"}, 32'(out_valid), 0);
            check({tag, "_leak"}, 32'({out_ovf, out_sum}), 0);
            tick();
        end
        check({tag, "_busy"}, 32'(in_ready), 0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 0);
        check({tag, "_drain_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_out_sum", 32'(out_sum), 0);
        tick();

        // 2-4. arithmetic
        run_op("add_100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0);
`ifdef SERIAL_ADD_SAT_EN
        run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd255, 1'b1);
        run_op("sub_20_50", 8'd20, 8'd50, 1'b1, 8'd0, 1'b1);
`else
        run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
        run_op("sub_20_50", 8'd20, 8'd50, 1'b1, 8'd226, 1'b1);
`endif
        run_op("sub_50_20", 8'd50, 8'd20, 1'b1, 8'd30, 1'b0);
        run_op("add_255_1", 8'd255, 8'd1, 1'b0, `ifdef SERIAL_ADD_SAT_EN 8'd255 `else 8'd0 `endif, 1'b1);
        run_op("sub_7_7", 8'd7, 8'd7, 1'b1, 8'd0, 1'b0);

        // 5. backpressure with in_valid held high
        in_a = 8'd10; in_b = 8'd5; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_a = 8'd3; in_b = 8'd4;
        for (int i = 0; i < W; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(out_sum), 15);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 1);
        check("bp_release_valid", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check("bp_reaccept", 32'(in_ready), 0);
        for (int i = 1; i < W; i++) tick();
        check("bp_second_early", 32'(out_valid), 0);
        tick();
        check("bp_second_valid", 32'(out_valid), 1);
        check("bp_second_sum", 32'(out_sum), 7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6. reset mid-RUN
        in_a = 8'd90; in_b = 8'd90; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(in_ready), 1);
        for (int i = 0; i < W + 2; i++) begin
            check("midrst_no_valid", 32'(out_valid), 0);
            tick();
        end
        run_op("add_1_1", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
